// File: rtl/vending_machine_credit.sv
// rtl/vending_machine_credit.sv - coin credit accumulator with dispense and unit change return
module vending_machine_credit #(
    parameter int CREDIT_W    = 8,
    parameter int PRICE       = 15,
    parameter int COIN_A      = 5,
    parameter int COIN_B      = 10,
    parameter int COIN_C      = 25,
    parameter int CHANGE_UNIT = 5,
    parameter int MAX_CREDIT  = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // One extra bit on the sum so an overflowing coin is detected instead of wrapping.
    localparam int SUM_W = CREDIT_W + 1;

    localparam logic [SUM_W-1:0]    VAL_A     = SUM_W'(COIN_A);
    localparam logic [SUM_W-1:0]    VAL_B     = SUM_W'(COIN_B);
    localparam logic [SUM_W-1:0]    VAL_C     = SUM_W'(COIN_C);
    localparam logic [SUM_W-1:0]    PRICE_S   = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0]    MAX_S     = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C    = CREDIT_W'(CHANGE_UNIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_reject_q, coin_reject_d;

    logic                coin_present;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;

    // State, credit and reject strobe registers; reset drops any owed change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // Next-state, credit arithmetic and reject decision.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;

        // coin_type 00 never counts as a coin, so it is neither credited nor rejected.
        coin_present = coin_valid && (coin_type != 2'b00);
        case (coin_type)
            2'b01:   coin_val = VAL_A;
            2'b10:   coin_val = VAL_B;
            2'b11:   coin_val = VAL_C;
            default: coin_val = '0;
        endcase
        sum = {1'b0, credit_q} + coin_val;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if ((state_q == S_COLLECT) && cancel) begin
                    // Refund the credit held before this cycle; a coin arriving now goes back.
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_present;
                end else if (coin_present) begin
                    if (sum <= MAX_S) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_S) ? S_DISPENSE : S_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_present;
                credit_d      = credit_q - PRICE_C;
                state_d       = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                coin_reject_d = coin_present;
                // Clamp at zero so a malformed remainder can never wrap into a long pulse train.
                if (credit_q <= UNIT_C) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    credit_d = credit_q - UNIT_C;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        dispense     = (state_q == S_DISPENSE);
        change_pulse = (state_q == S_CHANGE);
        busy         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
        coin_reject  = coin_reject_q;
        credit       = credit_q;
    end

endmodule

// File: tb/tb_vending_machine_credit.sv
// tb/tb_vending_machine_credit.sv - directed bench for vending_machine_credit
module tb_vending_machine_credit;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       cancel;
    logic       dispense;
    logic       change_pulse;
    logic       coin_reject;
    logic [7:0] credit;
    logic       busy;

    logic       coin_valid2;
    logic [1:0] coin_type2;
    logic       cancel2;
    logic       dispense2;
    logic       change_pulse2;
    logic       coin_reject2;
    logic [7:0] credit2;
    logic       busy2;

    int n_assert;
    int n_fail;

    vending_machine_credit dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    vending_machine_credit #(.PRICE(60)) dut60 (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid2),
        .coin_type    (coin_type2),
        .cancel       (cancel2),
        .dispense     (dispense2),
        .change_pulse (change_pulse2),
        .coin_reject  (coin_reject2),
        .credit       (credit2),
        .busy         (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic d, input logic c, input logic r,
                           input logic [7:0] cr, input logic b);
        chk({tag, ".dispense"}, {31'd0, dispense}, {31'd0, d});
        chk({tag, ".change"},   {31'd0, change_pulse}, {31'd0, c});
        chk({tag, ".reject"},   {31'd0, coin_reject}, {31'd0, r});
        chk({tag, ".credit"},   {24'd0, credit}, {24'd0, cr});
        chk({tag, ".busy"},     {31'd0, busy}, {31'd0, b});
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
        coin_type  = 2'b00;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        coin_valid  = 1'b1;
        coin_type   = 2'b11;
        cancel      = 1'b0;
        coin_valid2 = 1'b1;
        coin_type2  = 2'b11;
        cancel2     = 1'b0;

        // Reset held two cycles while a coin is presented.
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 8'd0, 0);
        chk("reset.p60_credit", {24'd0, credit2}, 32'd0);
        rst         = 1'b0;
        coin_valid  = 1'b0;
        coin_type   = 2'b00;
        coin_valid2 = 1'b0;
        coin_type2  = 2'b00;
        tick();
        chk_all("post_reset", 0, 0, 0, 8'd0, 0);

        // coin_valid with type 00 is ignored without a reject.
        coin(2'b00);
        chk_all("type00", 0, 0, 0, 8'd0, 0);

        // Exact payment: 5 then 10.
        coin(2'b01);
        chk_all("exact.c5", 0, 0, 0, 8'd5, 0);
        coin(2'b10);
        chk_all("exact.disp", 1, 0, 0, 8'd15, 1);
        tick();
        chk_all("exact.idle", 0, 0, 0, 8'd0, 0);
        tick();
        chk_all("exact.idle2", 0, 0, 0, 8'd0, 0);

        // Overpay with a single 25.
        coin(2'b11);
        chk_all("over.disp", 1, 0, 0, 8'd25, 1);
        tick();
        chk_all("over.chg1", 0, 1, 0, 8'd10, 1);
        tick();
        chk_all("over.chg2", 0, 1, 0, 8'd5, 1);
        tick();
        chk_all("over.idle", 0, 0, 0, 8'd0, 0);

        // Cancel after 5 + 5.
        coin(2'b01);
        coin(2'b01);
        chk_all("cancel.c10", 0, 0, 0, 8'd10, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk_all("cancel.chg1", 0, 1, 0, 8'd10, 1);
        tick();
        chk_all("cancel.chg2", 0, 1, 0, 8'd5, 1);
        tick();
        chk_all("cancel.idle", 0, 0, 0, 8'd0, 0);

        // Cancel together with a coin: coin rejected, refund of old credit only.
        coin(2'b01);
        coin(2'b01);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'b10;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        chk_all("cancelcoin.chg1", 0, 1, 1, 8'd10, 1);
        tick();
        chk_all("cancelcoin.chg2", 0, 1, 0, 8'd5, 1);
        tick();
        chk_all("cancelcoin.idle", 0, 0, 0, 8'd0, 0);

        // Coin inserted during CHANGE is rejected and pulse count is unchanged.
        coin(2'b11);
        chk_all("busyrej.disp", 1, 0, 0, 8'd25, 1);
        tick();
        chk_all("busyrej.chg1", 0, 1, 0, 8'd10, 1);
        coin(2'b11);
        chk_all("busyrej.chg2", 0, 1, 1, 8'd5, 1);
        tick();
        chk_all("busyrej.idle", 0, 0, 0, 8'd0, 0);

        // Coin inserted during DISPENSE: reject coincides with the first change pulse.
        coin(2'b11);
        chk_all("disprej.disp", 1, 0, 0, 8'd25, 1);
        coin(2'b01);
        chk_all("disprej.chg1", 0, 1, 1, 8'd10, 1);
        tick();
        chk_all("disprej.chg2", 0, 1, 0, 8'd5, 1);
        tick();
        chk_all("disprej.idle", 0, 0, 0, 8'd0, 0);

        // Reset in the middle of CHANGE drops the owed pulse.
        coin(2'b11);
        chk_all("rstchg.disp", 1, 0, 0, 8'd25, 1);
        tick();
        chk_all("rstchg.chg1", 0, 1, 0, 8'd10, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rstchg.reset", 0, 0, 0, 8'd0, 0);
        tick();
        chk_all("rstchg.idle", 0, 0, 0, 8'd0, 0);

        // PRICE=60 instance: overflow rejection, then exact reach of MAX_CREDIT.
        coin_valid2 = 1'b1;
        coin_type2  = 2'b11;
        tick();
        chk("p60.c25.credit", {24'd0, credit2}, 32'd25);
        chk("p60.c25.reject", {31'd0, coin_reject2}, 32'd0);
        tick();
        chk("p60.c50.credit", {24'd0, credit2}, 32'd50);
        tick();
        coin_valid2 = 1'b0;
        coin_type2  = 2'b00;
        chk("p60.ovf.credit", {24'd0, credit2}, 32'd50);
        chk("p60.ovf.reject", {31'd0, coin_reject2}, 32'd1);
        chk("p60.ovf.dispense", {31'd0, dispense2}, 32'd0);
        tick();
        chk("p60.hold.credit", {24'd0, credit2}, 32'd50);
        chk("p60.hold.reject", {31'd0, coin_reject2}, 32'd0);
        coin_valid2 = 1'b1;
        coin_type2  = 2'b10;
        tick();
        coin_valid2 = 1'b0;
        coin_type2  = 2'b00;
        chk("p60.max.credit", {24'd0, credit2}, 32'd60);
        chk("p60.max.dispense", {31'd0, dispense2}, 32'd1);
        chk("p60.max.busy", {31'd0, busy2}, 32'd1);
        tick();
        chk("p60.done.credit", {24'd0, credit2}, 32'd0);
        chk("p60.done.change", {31'd0, change_pulse2}, 32'd0);
        chk("p60.done.busy", {31'd0, busy2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
